// File: rtl/ex_stage.sv
// ex_stage: execute stage of a 5-stage MIPS pipeline.
// Resolves MEM/WB operand forwarding, runs the single-cycle ALU plus an
// iterative shift-add multiplier, and registers the EX/MEM result bundle.
// A multiply holds the upstream stages with ex_stall until its product is
// registered.
module ex_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_data1,
    input  logic [DATA_WIDTH-1:0] i_data2,
    input  logic [DATA_WIDTH-1:0] i_imme,
    input  logic [4:0]            i_rs,
    input  logic [4:0]            i_rt,
    input  logic [4:0]            i_rd,
    input  logic [5:0]            i_EX,
    input  logic [2:0]            i_M,
    input  logic [1:0]            i_WB,
    input  logic                  mem_regwrite,
    input  logic                  wb_regwrite,
    input  logic [4:0]            mem_rd,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic                  ex_stall,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [DATA_WIDTH-1:0] o_store,
    output logic [4:0]            o_dst,
    output logic [2:0]            o_M,
    output logic [1:0]            o_WB,
    output logic                  o_br_taken,
    output logic [DATA_WIDTH-1:0] o_br_target
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // Control-field decode
    logic            alu_src;
    logic            reg_dst;
    logic [3:0]      alu_op;
    logic            branch;
    logic [4:0]      shamt;

    assign alu_src = i_EX[5];
    assign reg_dst = i_EX[4];
    assign alu_op  = i_EX[3:0];
    assign branch  = i_M[2];
    assign shamt   = i_imme[10:6];

    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] br_target;
    logic [4:0]            dst;

    // Multiplier state
    mul_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] mcand_q;
    logic [DATA_WIDTH-1:0] mplier_q;
    logic [DATA_WIDTH-1:0] prod_q;
    logic [DATA_WIDTH-1:0] prod_d;
    logic [DATA_WIDTH-1:0] mul_store_q;
    logic [4:0]            mul_dst_q;
    logic [2:0]            mul_m_q;
    logic [1:0]            mul_wb_q;
    logic                  mul_start;

    // EX/MEM register
    logic [DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0] store_q;
    logic [4:0]            dst_q;
    logic [2:0]            m_q;
    logic [1:0]            wb_q;
    logic                  br_taken_q;
    logic [DATA_WIDTH-1:0] br_target_q;

    // Operand forwarding: MEM beats WB, and register 0 is never forwarded.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        fwd_a = i_data1;
        fwd_b = i_data2;
        if (mem_regwrite && (mem_rd == i_rs) && (i_rs != 5'd0)) begin
            fwd_a = mem_result;
        end else if (wb_regwrite && (wb_rd == i_rs) && (i_rs != 5'd0)) begin
            fwd_a = wb_data;
        end
        if (mem_regwrite && (mem_rd == i_rt) && (i_rt != 5'd0)) begin
            fwd_b = mem_result;
        end else if (wb_regwrite && (wb_rd == i_rt) && (i_rt != 5'd0)) begin
            fwd_b = wb_data;
        end
    end

    assign alu_b     = alu_src ? i_imme : fwd_b;
    assign dst       = reg_dst ? i_rd : i_rt;
    assign br_target = i_pc + (i_imme << 2);

    // Single-cycle ALU; MUL is produced by the iterative unit instead.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            OP_ADD:  alu_result = fwd_a + alu_b;
            OP_SUB:  alu_result = fwd_a - alu_b;
            OP_AND:  alu_result = fwd_a & alu_b;
            OP_OR:   alu_result = fwd_a | alu_b;
            OP_XOR:  alu_result = fwd_a ^ alu_b;
            OP_NOR:  alu_result = ~(fwd_a | alu_b);
            OP_SLT:  alu_result = DATA_WIDTH'($signed(fwd_a) < $signed(alu_b));
            OP_SLTU: alu_result = DATA_WIDTH'(fwd_a < alu_b);
            OP_SLL:  alu_result = alu_b << shamt;
            OP_SRL:  alu_result = alu_b >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(alu_b) >>> shamt);
            OP_LUI:  alu_result = alu_b << 16;
            default: alu_result = '0;
        endcase
    end

    // A bubble (all-zero M/WB) carrying a MUL opcode must not start the unit;
    // flush and reset always win over a start.
    assign mul_start = !rst && !flush && (state_q == ST_IDLE) &&
                       (alu_op == OP_MUL) && ({i_WB, i_M} != 5'd0);

    assign ex_stall  = !rst && (mul_start || (state_q != ST_IDLE));

    assign prod_d    = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

    // Multiply FSM: latch operands on start, one shift-add per BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            mul_store_q <= '0;
            mul_dst_q   <= '0;
            mul_m_q     <= '0;
            mul_wb_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mul_start) begin
                        state_q     <= ST_BUSY;
                        cnt_q       <= '0;
                        mcand_q     <= fwd_a;
                        mplier_q    <= alu_b;
                        prod_q      <= '0;
                        mul_store_q <= fwd_b;
                        mul_dst_q   <= dst;
                        mul_m_q     <= i_M;
                        mul_wb_q    <= i_WB;
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        prod_q   <= prod_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // EX/MEM register: product on DONE, bubble on flush/stall, else ALU result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            store_q     <= '0;
            dst_q       <= '0;
            m_q         <= '0;
            wb_q        <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            br_target_q <= br_target;
            if (!flush && (state_q == ST_DONE)) begin
                result_q   <= prod_q;
                store_q    <= mul_store_q;
                dst_q      <= mul_dst_q;
                m_q        <= mul_m_q;
                wb_q       <= mul_wb_q;
                br_taken_q <= 1'b0;
            end else if (flush || ex_stall) begin
                result_q   <= alu_result;
                store_q    <= fwd_b;
                dst_q      <= dst;
                m_q        <= '0;
                wb_q       <= '0;
                br_taken_q <= 1'b0;
            end else begin
                result_q   <= alu_result;
                store_q    <= fwd_b;
                dst_q      <= dst;
                m_q        <= i_M;
                wb_q       <= i_WB;
                br_taken_q <= branch && (fwd_a == fwd_b);
            end
        end
    end

    assign o_result    = result_q;
    assign o_store     = store_q;
    assign o_dst       = dst_q;
    assign o_M         = m_q;
    assign o_WB        = wb_q;
    assign o_br_taken  = br_taken_q;
    assign o_br_target = br_target_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed testbench for the ex_stage execute stage.
module tb_ex_stage;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [DW-1:0] i_pc, i_data1, i_data2, i_imme;
    logic [4:0]    i_rs, i_rt, i_rd;
    logic [5:0]    i_EX;
    logic [2:0]    i_M;
    logic [1:0]    i_WB;
    logic          mem_regwrite, wb_regwrite;
    logic [4:0]    mem_rd, wb_rd;
    logic [DW-1:0] mem_result, wb_data;
    logic          flush;
    logic          ex_stall;
    logic [DW-1:0] o_result, o_store, o_br_target;
    logic [4:0]    o_dst;
    logic [2:0]    o_M;
    logic [1:0]    o_WB;
    logic          o_br_taken;

    int errors = 0;
    int checks = 0;

    ex_stage #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_pc(i_pc), .i_data1(i_data1), .i_data2(i_data2), .i_imme(i_imme),
        .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
        .i_EX(i_EX), .i_M(i_M), .i_WB(i_WB),
        .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_result(mem_result), .wb_data(wb_data),
        .flush(flush), .ex_stall(ex_stall),
        .o_result(o_result), .o_store(o_store), .o_dst(o_dst),
        .o_M(o_M), .o_WB(o_WB),
        .o_br_taken(o_br_taken), .o_br_target(o_br_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load one ID/EX instruction onto the stage inputs.
    task automatic set_instr(input logic src, input logic rdst, input logic [3:0] op,
                             input logic [2:0] m, input logic [1:0] wb,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                             input logic [DW-1:0] imm);
        i_EX = {src, rdst, op};
        i_M = m; i_WB = wb;
        i_rs = rs; i_rt = rt; i_rd = rd;
        i_data1 = d1; i_data2 = d2; i_imme = imm;
    endtask

    task automatic no_forward();
        mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        mem_rd = 5'd0; wb_rd = 5'd0;
        mem_result = '0; wb_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; i_pc = '0;
        no_forward();
        set_instr(1'b0, 1'b0, 4'd0, 3'd0, 2'd0, 5'd0, 5'd0, 5'd0, '0, '0, '0);
        #12;
        checks++;
        if ({o_result, o_store, o_dst, o_M, o_WB, o_br_taken, o_br_target, ex_stall} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got result=%h dst=%0d M=%b WB=%b stall=%b, want all 0",
                     o_result, o_dst, o_M, o_WB, ex_stall);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        set_instr(1'b0, 1'b1, 4'd0, 3'd0, 2'b10, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, '0);
        #1;
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++; $display("FAIL add_stall: got %b want 0", ex_stall);
        end
        step();
        checks++;
        if (o_result !== 32'd12) begin
            errors++; $display("FAIL add_result: got %0d want 12", o_result);
        end
        checks++;
        if (o_dst !== 5'd3) begin
            errors++; $display("FAIL add_dst: got %0d want 3", o_dst);
        end
        checks++;
        if (o_WB !== 2'b10) begin
            errors++; $display("FAIL add_wb: got %b want 10", o_WB);
        end
    endtask

    task automatic test_forwarding();
        mem_regwrite = 1'b1; mem_rd = 5'd4; mem_result = 32'd100;
        wb_regwrite = 1'b1; wb_rd = 5'd4; wb_data = 32'd50;
        // SUB rs - imm, rs and rt both match MEM and WB
        set_instr(1'b1, 1'b0, 4'd1, 3'd0, 2'b10, 5'd4, 5'd4, 5'd0, 32'd20, 32'd30, 32'd1);
        step();
        checks++;
        if (o_result !== 32'd99) begin
            errors++; $display("FAIL fwd_mem: got %0d want 99", o_result);
        end
        checks++;
        if (o_store !== 32'd100) begin
            errors++; $display("FAIL fwd_store_mem: got %0d want 100", o_store);
        end
        mem_regwrite = 1'b0;
        step();
        checks++;
        if (o_result !== 32'd49) begin
            errors++; $display("FAIL fwd_wb: got %0d want 49", o_result);
        end
        mem_regwrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
        set_instr(1'b1, 1'b0, 4'd1, 3'd0, 2'b10, 5'd0, 5'd0, 5'd0, 32'd20, 32'd30, 32'd1);
        step();
        checks++;
        if (o_result !== 32'd19) begin
            errors++; $display("FAIL fwd_reg0: got %0d want 19", o_result);
        end
        no_forward();
    endtask

    task automatic test_branch();
        i_pc = 32'h100;
        set_instr(1'b0, 1'b0, 4'd1, 3'b100, 2'b00, 5'd1, 5'd2, 5'd0, 32'd9, 32'd9, 32'd4);
        step();
        checks++;
        if (o_br_taken !== 1'b1) begin
            errors++; $display("FAIL br_taken_eq: got %b want 1", o_br_taken);
        end
        checks++;
        if (o_br_target !== 32'h110) begin
            errors++; $display("FAIL br_target: got %h want 00000110", o_br_target);
        end
        i_data2 = 32'd8;
        step();
        checks++;
        if (o_br_taken !== 1'b0) begin
            errors++; $display("FAIL br_taken_ne: got %b want 0", o_br_taken);
        end
        i_pc = '0;
    endtask

    typedef struct {
        string      name;
        logic [3:0] op;
        logic       src;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic [DW-1:0] exp;
    } alu_vec_t;

    task automatic test_alu_ops();
        alu_vec_t v [8];
        v[0] = '{"sub_wrap", 4'd1,  1'b0, 32'd0,        32'd1,        32'd0,    32'hFFFFFFFF};
        v[1] = '{"nor",      4'd5,  1'b0, 32'hF0F0F0F0, 32'h0F0F0F00, 32'd0,    32'h0000000F};
        v[2] = '{"slt",      4'd6,  1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,    32'd1};
        v[3] = '{"sltu",     4'd7,  1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,    32'd0};
        v[4] = '{"srl",      4'd9,  1'b0, 32'd0,        32'h80000000, 32'h100,  32'h08000000};
        v[5] = '{"sra",      4'd10, 1'b0, 32'd0,        32'h80000000, 32'h100,  32'hF8000000};
        v[6] = '{"lui",      4'd11, 1'b1, 32'd0,        32'd0,        32'h1234, 32'h12340000};
        v[7] = '{"op13",     4'd13, 1'b0, 32'd3,        32'd4,        32'd0,    32'd0};
        for (int i = 0; i < 8; i++) begin
            set_instr(v[i].src, 1'b1, v[i].op, 3'd0, 2'b10, 5'd1, 5'd2, 5'd7,
                      v[i].a, v[i].b, v[i].imm);
            step();
            checks++;
            if (o_result !== v[i].exp) begin
                errors++;
                $display("FAIL alu_%s: got %h want %h", v[i].name, o_result, v[i].exp);
            end
        end
    endtask

    task automatic test_mul();
        int stall_cycles;
        stall_cycles = 0;
        set_instr(1'b0, 1'b1, 4'd12, 3'd0, 2'b10, 5'd1, 5'd2, 5'd5,
                  32'h0000FFFF, 32'h00010001, '0);
        #1;
        while (ex_stall === 1'b1 && stall_cycles < 100) begin
            stall_cycles++;
            step();
            // operands are latched; the upstream slot may already hold the next op
            if (stall_cycles == 1)
                set_instr(1'b0, 1'b1, 4'd0, 3'd0, 2'b10, 5'd1, 5'd2, 5'd6, 32'd1, 32'd2, '0);
            if (ex_stall === 1'b1) begin
                checks++;
                if (o_M !== 3'd0 || o_WB !== 2'd0) begin
                    errors++;
                    $display("FAIL mul_bubble: got M=%b WB=%b want 0/0 at stall cycle %0d",
                             o_M, o_WB, stall_cycles);
                end
            end
        end
        checks++;
        if (stall_cycles !== 34) begin
            errors++; $display("FAIL mul_stall_len: got %0d want 34", stall_cycles);
        end
        checks++;
        if (o_result !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL mul_result: got %h want ffffffff", o_result);
        end
        checks++;
        if (o_dst !== 5'd5 || o_WB !== 2'b10) begin
            errors++; $display("FAIL mul_ctrl: got dst=%0d WB=%b want 5/10", o_dst, o_WB);
        end
        step();
        checks++;
        if (o_result !== 32'd3 || o_dst !== 5'd6) begin
            errors++; $display("FAIL mul_next_add: got %0d dst=%0d want 3 dst=6", o_result, o_dst);
        end
    endtask

    task automatic test_flush_mul();
        set_instr(1'b0, 1'b1, 4'd12, 3'd0, 2'b10, 5'd1, 5'd2, 5'd5, 32'd3, 32'd4, '0);
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (ex_stall !== 1'b1) begin
            errors++; $display("FAIL flush_pre_stall: got %b want 1", ex_stall);
        end
        flush = 1'b1;
        set_instr(1'b0, 1'b1, 4'd0, 3'd0, 2'b10, 5'd1, 5'd2, 5'd8, 32'd10, 32'd20, '0);
        step();
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall_drop: got %b want 0", ex_stall);
        end
        checks++;
        if (o_WB !== 2'd0 || o_M !== 3'd0) begin
            errors++; $display("FAIL flush_bubble: got WB=%b M=%b want 0", o_WB, o_M);
        end
        flush = 1'b0;
        step();
        checks++;
        if (o_result !== 32'd30 || o_WB !== 2'b10 || o_dst !== 5'd8) begin
            errors++;
            $display("FAIL flush_next_add: got %0d WB=%b dst=%0d want 30/10/8", o_result, o_WB, o_dst);
        end
    endtask

    task automatic test_flush_start();
        flush = 1'b1;
        set_instr(1'b0, 1'b1, 4'd12, 3'd0, 2'b10, 5'd1, 5'd2, 5'd5, 32'd3, 32'd4, '0);
        #1;
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++; $display("FAIL flush_start_stall: got %b want 0", ex_stall);
        end
        step();
        checks++;
        if (o_WB !== 2'd0) begin
            errors++; $display("FAIL flush_start_bubble: got WB=%b want 0", o_WB);
        end
        flush = 1'b0;
        set_instr(1'b0, 1'b1, 4'd0, 3'd0, 2'b10, 5'd1, 5'd2, 5'd9, 32'd1, 32'd1, '0);
        #1;
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++; $display("FAIL flush_start_idle: got %b want 0", ex_stall);
        end
    endtask

    task automatic test_async_reset();
        i_pc = 32'h200;
        set_instr(1'b0, 1'b1, 4'd12, 3'd0, 2'b10, 5'd1, 5'd2, 5'd5, 32'd3, 32'd4, '0);
        for (int i = 0; i < 5; i++) step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({o_result, o_dst, o_M, o_WB, o_br_taken, o_br_target} !== '0) begin
            errors++;
            $display("FAIL async_reset_out: got result=%h dst=%0d WB=%b target=%h want 0",
                     o_result, o_dst, o_WB, o_br_target);
        end
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++; $display("FAIL async_reset_stall: got %b want 0", ex_stall);
        end
        i_pc = '0;
        set_instr(1'b0, 1'b1, 4'd0, 3'd0, 2'b10, 5'd1, 5'd2, 5'd4, 32'd40, 32'd2, '0);
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (o_result !== 32'd42 || o_dst !== 5'd4 || ex_stall !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_resume: got %0d dst=%0d stall=%b want 42/4/0",
                     o_result, o_dst, ex_stall);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_forwarding();
        test_branch();
        test_alu_ops();
        test_mul();
        test_flush_mul();
        test_flush_start();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
